hif_fir_reader: RTL and testbench
=================================

HIF_FIR_READER -- requirements
Module: hif_fir_reader

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 1021: number of taps per filtered output, legal range 1..1024.
REQ-002 SHALL have parameter COEFF_AW, default 10: width of the coefficient ROM address.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port sequencing, input, 1 bit: high-frequency queue full and streaming.
REQ-006 SHALL have port wrt_smpl, input, 1 bit: one-clk pulse, new sample written to queue.
REQ-007 SHALL have port smpl_in, input, 16 bits: signed queue read data, 1-clk latency after rd_inc.
REQ-008 SHALL have port coeff, input, 16 bits: signed Q1.15 ROM data, 1-clk latency after coeff_addr.
REQ-009 SHALL have port rd_inc, output, 1 bit: advance queue read pointer by one.
REQ-010 SHALL have port coeff_addr, output, COEFF_AW bits: coefficient ROM address.
REQ-011 SHALL have port filt_out, output, 16 bits: signed saturated filter result.
REQ-012 SHALL have port filt_vld, output, 1 bit: one-clk pulse, filt_out valid.
REQ-013 SHALL have port busy, output, 1 bit: FSM not IDLE.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, wrt_smpl arrived while busy.

Function
REQ-015 SHALL implement FSM states IDLE, PRIME, MAC, DONE.
REQ-016 SHALL go IDLE->PRIME when wrt_smpl and sequencing are both high at a rising clk edge (cycle 0); otherwise SHALL stay in IDLE.
REQ-017 SHALL, in PRIME (cycle 1), clear the accumulator, drive coeff_addr=0 and assert rd_inc, then go to MAC.
REQ-018 SHALL assert rd_inc in exactly NUM_TAPS cycles per run (cycles 1..NUM_TAPS), incrementing coeff_addr by one each cycle up to NUM_TAPS-1.
REQ-019 SHALL, in MAC, accumulate the 32-bit signed product smpl_in*coeff into a 42-bit signed accumulator on cycles 2..NUM_TAPS+1, tap k being consumed on cycle k+2.
REQ-020 SHALL go MAC->DONE after the NUM_TAPS-th accumulate; in DONE it SHALL take acc>>>15, saturate to [0x8000,0x7FFF], register the result onto filt_out and pulse filt_vld in cycle NUM_TAPS+2, then return to IDLE.
REQ-021 SHALL hold filt_out until the next filt_vld.
REQ-022 SHALL NOT assert rd_inc or change coeff_addr in IDLE or DONE; coeff_addr SHALL return to 0 in IDLE.
REQ-023 SHALL set overrun when wrt_smpl is high while busy; that sample SHALL NOT start a run; overrun SHALL clear only on reset.
REQ-024 SHALL abort to IDLE if sequencing falls while busy, with no filt_vld and filt_out unchanged.
REQ-025 SHALL let a wrt_smpl in the same cycle as DONE set overrun and SHALL NOT start a run.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force: state=IDLE, accumulator=0, coeff_addr=0, rd_inc=0, filt_out=0x0000, filt_vld=0, busy=0, overrun=0.
REQ-027 SHALL abandon a run interrupted by reset with no filt_vld, and SHALL accept a new run on the first qualifying wrt_smpl after deassertion.

Configuration
REQ-028 SHALL, with HIF_FIR_ROUND_EN defined, add 2^14 to the accumulator before the >>>15 shift and saturation.
REQ-029 SHALL, without HIF_FIR_ROUND_EN, truncate (>>>15) with no rounding add.

Verification (NUM_TAPS=4 for all)
REQ-030 SHALL verify: coeff all 0x4000, smpl_in all 0x2000, one wrt_smpl with sequencing=1 -> exactly 4 rd_inc pulses, coeff_addr 0..3, filt_vld 6 cycles after wrt_smpl, filt_out=0x4000.
REQ-031 SHALL verify: coeff all 0x7FFF, smpl_in all 0x7FFF -> filt_out=0x7FFF; smpl_in all 0x8000 -> filt_out=0x8000.
REQ-032 SHALL verify: coeff={0x0001,0,0,0}, smpl_in=0x4000 -> filt_out=0x0001 with HIF_FIR_ROUND_EN, 0x0000 without.
REQ-033 SHALL verify: second wrt_smpl 2 cycles after the first -> overrun=1, only one filt_vld, overrun stays 1 until rst_n low.
REQ-034 SHALL verify: sequencing dropped in cycle 3 of a run -> busy=0 next cycle, no filt_vld, filt_out unchanged; wrt_smpl with sequencing=0 -> no rd_inc.
REQ-035 SHALL verify: rst_n asserted mid-MAC -> all outputs at reset values immediately; the next run after release gives the correct result.

Source files
------------

// File: rtl/hif_fir_reader.sv
// Streaming FIR reader: on each qualified new sample, reads NUM_TAPS samples and coefficients and emits one saturated Q1.15 result.
// Optional macro HIF_FIR_ROUND_EN: round half-up before the >>>15 instead of truncating.
module hif_fir_reader #(
  parameter int NUM_TAPS = 1021,
  parameter int COEFF_AW = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sequencing,
  input  logic                       wrt_smpl,
  input  logic signed [15:0]         smpl_in,
  input  logic signed [15:0]         coeff,
  output logic                       rd_inc,
  output logic        [COEFF_AW-1:0] coeff_addr,
  output logic        [15:0]         filt_out,
  output logic                       filt_vld,
  output logic                       busy,
  output logic                       overrun
);

  typedef enum logic [1:0] {IDLE, PRIME, MAC, DONE} state_t;

  localparam logic [10:0]         LAST_TAP  = 11'(NUM_TAPS - 1);
  localparam logic [COEFF_AW-1:0] LAST_ADDR = COEFF_AW'(NUM_TAPS - 1);

  state_t               state_q, state_d;
  logic signed [41:0]   acc_q, acc_d;
  logic [10:0]          cnt_q, cnt_d;
  logic [COEFF_AW-1:0]  addr_q, addr_d;
  logic [15:0]          filt_q, filt_d;
  logic                 vld_q, vld_d;
  logic                 ovr_q, ovr_d;

  logic signed [31:0]   prod;
  logic signed [41:0]   acc_sum;
  logic signed [41:0]   acc_rnd;
  logic signed [26:0]   acc_shr;
  logic        [15:0]   sat_val;

  // Result is taken from the sum including the final tap, so it can be registered on the MAC->DONE edge.
  always_comb begin
    prod    = smpl_in * coeff;
    acc_sum = acc_q + {{10{prod[31]}}, prod};
`ifdef HIF_FIR_ROUND_EN
    acc_rnd = acc_sum + 42'sd16384;
`else
    acc_rnd = acc_sum;
`endif
    acc_shr = acc_rnd[41:15];
    if (acc_shr > 27'sd32767)
      sat_val = 16'h7FFF;
    else if (acc_shr < -27'sd32768)
      sat_val = 16'h8000;
    else
      sat_val = acc_shr[15:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    filt_d  = filt_q;
    vld_d   = 1'b0;
    ovr_d   = ovr_q | (wrt_smpl & (state_q != IDLE));
    rd_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (wrt_smpl && sequencing) state_d = PRIME;
      end
      PRIME: begin
        rd_inc = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
        if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
        if (sequencing) begin
          state_d = MAC;
        end else begin
          state_d = IDLE;
          addr_d  = '0;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        // Fetch for tap cnt_q+1 overlaps the consume of tap cnt_q.
        if (cnt_q != LAST_TAP) begin
          rd_inc = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
        end
        if (!sequencing) begin
          state_d = IDLE;
          addr_d  = '0;
        end else if (cnt_q == LAST_TAP) begin
          state_d = DONE;
          filt_d  = sat_val;
          vld_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      filt_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      filt_q  <= filt_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign coeff_addr = addr_q;
  assign filt_out   = filt_q;
  assign filt_vld   = vld_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_hif_fir_reader.sv
// Directed + randomized bench for hif_fir_reader with NUM_TAPS=4; reference result from plain integer arithmetic.
module tb_hif_fir_reader;

  localparam int NT = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sequencing = 1'b0;
  logic               wrt_smpl = 1'b0;
  logic signed [15:0] smpl_in = '0;
  logic signed [15:0] coeff = '0;
  logic               rd_inc;
  logic [9:0]         coeff_addr;
  logic [15:0]        filt_out;
  logic               filt_vld;
  logic               busy;
  logic               overrun;

  hif_fir_reader #(.NUM_TAPS(NT), .COEFF_AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .sequencing(sequencing), .wrt_smpl(wrt_smpl),
    .smpl_in(smpl_in), .coeff(coeff), .rd_inc(rd_inc), .coeff_addr(coeff_addr),
    .filt_out(filt_out), .filt_vld(filt_vld), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic signed [15:0] smem [NT];
  logic signed [15:0] cmem [NT];
  int rp = 0;
  int cyc = 0;

  // Sample queue and coefficient ROM, both with one clock of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    coeff <= (coeff_addr < 10'(NT)) ? cmem[coeff_addr[1:0]] : 16'sh0;
    if (wrt_smpl && sequencing && !busy) rp <= 0;
    else if (rd_inc) begin
      smpl_in <= (rp < NT) ? smem[rp] : 16'sh0;
      rp <= rp + 1;
    end
  end

  int rd_cnt = 0, vld_cnt = 0, vld_cyc = 0;
  logic [15:0] vld_val = '0;
  logic [9:0]  addr_log [8];
  always @(negedge clk) begin
    if (rd_inc) begin
      if (rd_cnt < 8) addr_log[rd_cnt] = coeff_addr;
      rd_cnt++;
    end
    if (filt_vld) begin
      vld_cnt++;
      vld_cyc = cyc;
      vld_val = filt_out;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_fir();
    longint s = 0;
    for (int k = 0; k < NT; k++) s += longint'(smem[k]) * longint'(cmem[k]);
`ifdef HIF_FIR_ROUND_EN
    s += 16384;
`endif
    s = s >>> 15;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic fill(input logic [15:0] s, input logic [15:0] c);
    for (int k = 0; k < NT; k++) begin
      smem[k] = s;
      cmem[k] = c;
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic fill_rand;
    for (int k = 0; k < NT; k++) begin
      smem[k] = rnd16();
      cmem[k] = rnd16();
    end
  endtask

  task automatic clear_mon;
    rd_cnt = 0;
    vld_cnt = 0;
    vld_cyc = 0;
  endtask

  task automatic wait_vld(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (vld_cnt > 0) seen = 1;
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
    repeat (3) tick();
  endtask

  task automatic do_run(input string tag, output int start);
    clear_mon();
    wrt_smpl = 1'b1;
    start = cyc;
    tick();
    wrt_smpl = 1'b0;
    wait_vld(tag);
  endtask

  initial begin
    int st;
    logic [15:0] exp_v, held;

    repeat (3) tick();
    check("rst_filt_out", 32'(filt_out), 32'h0);
    check("rst_filt_vld", 32'(filt_vld), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_rd_inc", 32'(rd_inc), 32'h0);
    check("rst_coeff_addr", 32'(coeff_addr), 32'h0);
    rst_n = 1'b1;
    tick();
    sequencing = 1'b1;

    fill(16'h2000, 16'h4000);
    do_run("basic", st);
    check("basic_rd_cnt", 32'(rd_cnt), 32'd4);
    for (int k = 0; k < NT; k++) check("basic_addr", 32'(addr_log[k]), 32'(k));
    check("basic_latency", 32'(vld_cyc - st), 32'd6);
    check("basic_vld_cnt", 32'(vld_cnt), 32'd1);
    check("basic_out", 32'(vld_val), 32'h4000);
    check("basic_addr_idle", 32'(coeff_addr), 32'h0);
    repeat (5) tick();
    check("basic_hold", 32'(filt_out), 32'h4000);

    fill(16'h7FFF, 16'h7FFF);
    do_run("sat_pos", st);
    check("sat_pos_out", 32'(vld_val), 32'h7FFF);
    fill(16'h8000, 16'h7FFF);
    do_run("sat_neg", st);
    check("sat_neg_out", 32'(vld_val), 32'h8000);

    fill(16'h4000, 16'h0000);
    cmem[0] = 16'h0001;
`ifdef HIF_FIR_ROUND_EN
    exp_v = 16'h0001;
`else
    exp_v = 16'h0000;
`endif
    do_run("round", st);
    check("round_out", 32'(vld_val), 32'(exp_v));

    for (int r = 0; r < 6; r++) begin
      fill_rand();
      exp_v = ref_fir();
      do_run("rand", st);
      check("rand_out", 32'(vld_val), 32'(exp_v));
      check("rand_vld_cnt", 32'(vld_cnt), 32'd1);
      check("rand_rd_cnt", 32'(rd_cnt), 32'd4);
    end

    // Abort: sequencing low in cycle 3 of a run.
    held = filt_out;
    fill_rand();
    clear_mon();
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    tick();
    tick();
    sequencing = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'h0);
    repeat (8) tick();
    check("abort_no_vld", 32'(vld_cnt), 32'd0);
    check("abort_hold", 32'(filt_out), 32'(held));
    clear_mon();
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    repeat (6) tick();
    check("noseq_rd_cnt", 32'(rd_cnt), 32'd0);
    check("noseq_busy", 32'(busy), 32'h0);
    check("noseq_overrun", 32'(overrun), 32'h0);
    sequencing = 1'b1;
    tick();

    // Second sample two cycles into a run.
    fill_rand();
    exp_v = ref_fir();
    clear_mon();
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    tick();
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    wait_vld("ovr");
    repeat (6) tick();
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_vld_cnt", 32'(vld_cnt), 32'd1);
    check("ovr_out", 32'(vld_val), 32'(exp_v));
    fill_rand();
    exp_v = ref_fir();
    do_run("ovr_next", st);
    check("ovr_next_out", 32'(vld_val), 32'(exp_v));
    check("ovr_sticky", 32'(overrun), 32'h1);

    // Reset in the middle of MAC.
    fill_rand();
    clear_mon();
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_rd_inc", 32'(rd_inc), 32'h0);
    check("mrst_coeff_addr", 32'(coeff_addr), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_filt_vld", 32'(filt_vld), 32'h0);
    check("mrst_filt_out", 32'(filt_out), 32'h0);
    check("mrst_overrun", 32'(overrun), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("mrst_no_vld", 32'(vld_cnt), 32'd0);
    fill_rand();
    exp_v = ref_fir();
    do_run("post_rst", st);
    check("post_rst_out", 32'(vld_val), 32'(exp_v));
    check("post_rst_latency", 32'(vld_cyc - st), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
